// File: rtl/rbm_mult_sched_pkg.sv
// Shared types and default widths for the RBM multiply scheduler.
package rbm_sched_pkg;
    localparam int DATA_WIDTH = 128;
    localparam int NUM_WIDTH  = DATA_WIDTH / 4;
    localparam int PROD_WIDTH = 2 * NUM_WIDTH;
    localparam int DP_LATENCY = 3;
    // Tag index is sized for the largest supported requester count (8).
    localparam int TAG_IDX_W  = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;
endpackage

// File: rtl/rbm_mult_sched_if.sv
// Avalon-MM write/read bus between the scheduler and the multiply datapath.
interface rbm_mult_sched_if #(
    parameter int DATA_WIDTH = 128
) ();
    logic                  dp_write;
    logic                  dp_read;
    logic [DATA_WIDTH-1:0] dp_writedata;
    logic [DATA_WIDTH-1:0] dp_readdata;
    logic                  dp_readdatavalid;
    logic                  dp_waitrequest;

    modport master (
        output dp_write, dp_read, dp_writedata,
        input  dp_readdata, dp_readdatavalid, dp_waitrequest
    );
    modport slave (
        input  dp_write, dp_read, dp_writedata,
        output dp_readdata, dp_readdatavalid, dp_waitrequest
    );
endinterface

// File: rtl/rbm_mult_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner,
    output logic          any
);
    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/rbm_mult_sched.sv
// Arbitrates requesters onto the fixed-latency multiply datapath and routes
// each product back to its requester using a tag delay line.
module rbm_mult_sched
    import rbm_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = rbm_sched_pkg::DATA_WIDTH,
    parameter int NUM_WIDTH  = DATA_WIDTH / 4,
    parameter int PROD_WIDTH = 2 * NUM_WIDTH,
    parameter int DP_LATENCY = rbm_sched_pkg::DP_LATENCY
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_enable,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*NUM_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*NUM_WIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [NUM_REQ*PROD_WIDTH-1:0] rsp_data,
    rbm_mult_sched_if.master              dp,
    output logic                          busy,
    output logic [15:0]                   issue_count
);
    localparam int IW = $clog2(NUM_REQ);
    // One stage for the dp_write register, DP_LATENCY in the datapath, one for capture.
    localparam int TAG_STAGES = DP_LATENCY + 2;

    state_e                               state_q, state_d;
    logic [IW-1:0]                        rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]                   slot_busy_q, slot_busy_d;
    logic [NUM_REQ-1:0]                   rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][PROD_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [15:0]                          issue_count_q, issue_count_d;
    logic                                 dp_write_q, dp_write_d;
    logic [DATA_WIDTH-1:0]                dp_wdata_q, dp_wdata_d;
    tag_t [TAG_STAGES-1:0]                tag_q, tag_d;

    logic [NUM_REQ-1:0]   eligible, grant;
    logic [IW-1:0]        winner;
    logic                 gnt_any, tag_busy;
    logic [NUM_WIDTH-1:0] sel_a, sel_b;
    tag_t                 cap;
    logic                 unused_dp;

    assign eligible = req_valid & ~slot_busy_q
                    & {NUM_REQ{(state_q == RUN) && !dp.dp_waitrequest}};

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req    (eligible),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (gnt_any)
    );

    assign req_ready = grant;
    assign cap       = tag_q[TAG_STAGES-1];

    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        tag_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*NUM_WIDTH +: NUM_WIDTH];
                sel_b = req_b[i*NUM_WIDTH +: NUM_WIDTH];
            end
        end
        for (int k = 0; k < TAG_STAGES; k++) tag_busy = tag_busy | tag_q[k].valid;
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        slot_busy_d   = slot_busy_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        issue_count_d = issue_count_q;
        dp_write_d    = gnt_any;
        dp_wdata_d    = dp_wdata_q;
        tag_d[0].valid = gnt_any;
        tag_d[0].idx   = TAG_IDX_W'(winner);
        for (int k = 1; k < TAG_STAGES; k++) tag_d[k] = tag_q[k-1];

        unique case (state_q)
            IDLE:    if (cfg_enable) state_d = RUN;
            RUN:     if (!cfg_enable) state_d = DRAIN;
            DRAIN:   if (slot_busy_q == '0 && !tag_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (gnt_any) begin
            rr_ptr_d      = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            issue_count_d = issue_count_q + 16'd1;
            dp_wdata_d    = {sel_b, sel_a, {(DATA_WIDTH - 2*NUM_WIDTH){1'b0}}};
        end

        // A slot is busy from grant until its product is handed over, so a
        // capture and a handshake never target the same requester together.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid_q[i] && rsp_ready[i]) begin
                rsp_valid_d[i] = 1'b0;
                slot_busy_d[i] = 1'b0;
            end
            if (cap.valid && cap.idx == TAG_IDX_W'(i)) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = dp.dp_readdata[PROD_WIDTH-1:0];
            end
        end
        slot_busy_d = slot_busy_d | grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            slot_busy_q   <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            issue_count_q <= '0;
            dp_write_q    <= 1'b0;
            dp_wdata_q    <= '0;
            tag_q         <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            slot_busy_q   <= slot_busy_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            issue_count_q <= issue_count_d;
            dp_write_q    <= dp_write_d;
            dp_wdata_q    <= dp_wdata_d;
            tag_q         <= tag_d;
        end
    end

    assign dp.dp_write     = dp_write_q;
    assign dp.dp_read      = 1'b0;
    assign dp.dp_writedata = dp_wdata_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign busy            = (state_q != IDLE);
    assign issue_count     = issue_count_q;

    // Only the low product bits are meaningful; readdatavalid is not a beat strobe.
    assign unused_dp = ^{dp.dp_readdatavalid, dp.dp_readdata[DATA_WIDTH-1:PROD_WIDTH]};
endmodule

// File: doc/rbm_mult_sched.md
Name: rbm_mult_sched

Overview:
- Multi-requester scheduler in front of the 128-bit Avalon-MM multiply datapath: round-robin arbitration of NUM_REQ operand pairs, operand packing, Avalon write issue, fixed-latency result capture and per-requester response routing.
- The datapath has no per-beat valid and no ID return, so results are matched to requesters by an internal tag delay line.
- Sits between the RBM compute clients and the datapath slave, sharing the clock and reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 128, datapath bus width.
- NUM_WIDTH, DATA_WIDTH/4, operand width.
- PROD_WIDTH, 2*NUM_WIDTH, returned product width.
- DP_LATENCY, 3, edges from the datapath sampling dp_write to dp_readdata holding the product.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_enable  in  1  allow new grants.
- req_valid  in  NUM_REQ  operand pair offered.
- req_ready  out  NUM_REQ  grant, one-hot or zero, combinational.
- req_a  in  NUM_REQ*NUM_WIDTH  packed first operands, requester i at [i*NUM_WIDTH +: NUM_WIDTH].
- req_b  in  NUM_REQ*NUM_WIDTH  packed second operands, same packing.
- rsp_valid  out  NUM_REQ  product held for requester i.
- rsp_ready  in  NUM_REQ  requester accepts product.
- rsp_data  out  NUM_REQ*PROD_WIDTH  packed products.
- dp_write  out  1  datapath write strobe.
- dp_read  out  1  tied 0.
- dp_writedata  out  DATA_WIDTH  packed operands.
- dp_readdata  in  DATA_WIDTH  datapath result.
- dp_readdatavalid  in  1  ignored (not a per-beat strobe).
- dp_waitrequest  in  1  datapath stall.
- busy  out  1  state != IDLE.
- issue_count  out  16  grants since reset, wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values: dp_write=0, dp_writedata=0, rsp_valid=0, rsp_data=0, issue_count=0, rr_ptr=0, state=IDLE, tag line cleared, all slot_busy=0. A reset mid-operation discards in-flight work; the datapath shares the reset.
- FSM:
  - IDLE -> RUN when cfg_enable=1.
  - RUN -> DRAIN when cfg_enable=0.
  - DRAIN -> IDLE when no slot_busy and the tag line is empty.
  - cfg_enable=1 during DRAIN is ignored until IDLE.
  - Grants only in RUN.
- Eligibility: i is eligible when req_valid[i] & ~slot_busy[i] & ~dp_waitrequest & state==RUN.
- Winner: first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready is one-hot on the winner.
- On transfer (edge with req_valid & req_ready):
  - rr_ptr <= winner+1 mod NUM_REQ.
  - slot_busy[winner] <= 1.
  - issue_count++.
  - dp_write <= 1 for exactly one cycle.
  - dp_writedata <= {b, a, 64'b0}: a at [95:64], b at [127:96], lower 64 bits zero.
- Tag delay line: {valid, index}, DP_LATENCY+2 stages, loaded on the transfer edge. Its output qualifies capture: rsp_data[idx] <= dp_readdata[PROD_WIDTH-1:0] and rsp_valid[idx] <= 1.
- Timing: if transfer occurs at edge E0, the datapath samples at E1, the product is on dp_readdata after E1+DP_LATENCY, and rsp_valid rises after E0+DP_LATENCY+2 (5 edges at default).
- Response handshake: rsp_valid/rsp_data hold until rsp_ready. On the handshake edge rsp_valid<=0 and slot_busy<=0. Requester i is eligible again from the next cycle. Max one outstanding per requester, so a slot never overflows.
- Back-to-back: different requesters may be granted on consecutive cycles (one issue per cycle max). Captures arrive in issue order, one per cycle.
- dp_waitrequest=1 blocks grants in that cycle only. An already-registered dp_write is not extended.
- Arithmetic is unsigned; the product is the low PROD_WIDTH bits of dp_readdata.

Decomposition:
- Package rbm_sched_pkg:
  - localparams DATA_WIDTH, NUM_WIDTH, PROD_WIDTH, DP_LATENCY.
  - FSM state typedef {IDLE, RUN, DRAIN}.
  - tag struct {valid, idx[$clog2(NUM_REQ)-1:0]}.
- One sub-module rr_arbiter (req vector, ptr -> one-hot grant, winner index). Everything else lives in the top.

Test Plan:
- Single op: cfg_enable=1, req0 a=3 b=7 -> dp_writedata[127:64]={7,3} one cycle after grant; rsp_valid[0] 5 edges after transfer with rsp_data=21; issue_count=1.
- Fairness: all 4 requesters held valid, responses accepted immediately -> grant order 0,1,2,3,0,...; no requester granted twice before the others are each granted once.
- Backpressure: rsp_ready[2]=0 -> req2 gets no second grant while its product 0xFFFFFFFF*0xFFFFFFFF=0xFFFFFFFE00000001 is held; the other requesters continue; releasing rsp_ready re-enables req2 next cycle.
- Drain: 3 ops in flight, drop cfg_enable -> no new req_ready, busy=1 until the last response handshake, then state IDLE, busy=0.
- Stall and reset: dp_waitrequest=1 for 4 cycles -> no grants or dp_write. Then reset asserted two cycles after a grant -> all outputs at reset values next edge, and no stray rsp_valid afterwards.
